// File: rtl/event_blinker.sv
// Turns one-cycle event pulses into LED blinks (ON then OFF); extra pulses queue in a saturating counter.
// Outputs registered, 1-cycle pulse-to-LED latency; never backpressures. EVENT_BLINKER_PWM_EN dims the ON phase.
module event_blinker #(
  parameter int unsigned ON_CYCLES  = 10_000_000,
  parameter int unsigned OFF_CYCLES = 10_000_000,
  parameter int unsigned PEND_WIDTH = 4,
  parameter int unsigned DUTY       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev_pulse,
  output logic                  led_out,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]         ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]         OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [PEND_WIDTH-1:0]   pend_q, pend_d;
  logic                    ovf_q, ovf_d;
  logic                    led_q, led_d;
  logic                    busy_q, busy_d;
  logic                    queue_ev;

`ifdef EVENT_BLINKER_PWM_EN
  logic [7:0] pwm_q, pwm_d;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    queue_ev = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev_pulse) begin
          state_d = ST_ON;
          timer_d = '0;
        end
      end
      ST_ON: begin
        queue_ev = ev_pulse;
        if (timer_q == ON_LAST) begin
          state_d = ST_OFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_OFF: begin
        if (timer_q == OFF_LAST) begin
          // A pulse on the final OFF cycle starts the next blink directly,
          // so it cancels against the dequeue instead of being queued.
          if ((pend_q != '0) || ev_pulse) begin
            state_d = ST_ON;
            timer_d = '0;
            if ((pend_q != '0) && !ev_pulse) begin
              pend_d = pend_q - PEND_WIDTH'(1);
            end
          end else begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end else begin
          queue_ev = ev_pulse;
          timer_d  = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (queue_ev) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_WIDTH'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);
`ifdef EVENT_BLINKER_PWM_EN
    pwm_d = pwm_q + 8'd1;
    led_d = (state_d == ST_ON) && ({1'b0, pwm_d} < 9'(DUTY));
`else
    led_d = (state_d == ST_ON);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

`ifdef EVENT_BLINKER_PWM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_event_blinker.sv
// Scoreboard bench for event_blinker (ON=4, OFF=3, PEND_WIDTH=2): reference model pushes expected outputs per cycle.
module tb_event_blinker;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 3;
  localparam int PW     = 2;
  localparam int PERIOD = ON_C + OFF_C;
  localparam int PMAX   = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev_pulse = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  event_blinker #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .PEND_WIDTH(PW),
    .DUTY      (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_pulse(ev_pulse),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int led;
    int busy;
    int pend;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining cycles of the current blink (0 = idle)
  int m_left = 0;
  int m_pend = 0;
  int m_ovf  = 0;

  int rises    = 0;
  int prev_led = 0;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_step(input int r, input int e);
    exp_t x;
    if (r != 0) begin
      m_left = 0;
      m_pend = 0;
      m_ovf  = 0;
    end else if (m_left == 0) begin
      if (e != 0) m_left = PERIOD;
    end else if (m_left == 1) begin
      if (m_pend > 0 || e != 0) begin
        m_left = PERIOD;
        if (m_pend > 0 && e == 0) m_pend--;
      end else begin
        m_left = 0;
      end
    end else begin
      m_left--;
      if (e != 0) begin
        if (m_pend == PMAX) m_ovf = 1;
        else m_pend++;
      end
    end
    x.led  = (m_left > OFF_C) ? 1 : 0;
    x.busy = (m_left > 0) ? 1 : 0;
    x.pend = m_pend;
    x.ovf  = m_ovf;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic r, input logic e, input string tag);
    exp_t x;
    rst      = r;
    ev_pulse = e;
    model_step(int'(r), int'(e));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      x = exp_q.pop_front();
      check({tag, "_led"}, int'(led_out), x.led);
      check({tag, "_busy"}, int'(busy), x.busy);
      check({tag, "_pend"}, int'(pending), x.pend);
      check({tag, "_ovf"}, int'(overflow), x.ovf);
    end
    if (led_out === 1'b1 && prev_led == 0) rises++;
    prev_led = (led_out === 1'b1) ? 1 : 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, "rst");
    step(1'b1, 1'b1, "rst_ev");

    // Single pulse: one blink, back to idle at cycle 8
    rises = 0;
    step(1'b0, 1'b1, "t1");
    idle(10, "t1");
    check("t1_blinks", rises, 1);

    // Four consecutive pulses: four back-to-back blinks
    rises = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "t2");
    idle(30, "t2");
    check("t2_blinks", rises, 4);

    // Pulse on last OFF cycle, pending empty
    rises = 0;
    step(1'b0, 1'b1, "t4a");
    idle(6, "t4a");
    step(1'b0, 1'b1, "t4a_last");
    check("t4a_busy_held", int'(busy), 1);
    idle(10, "t4a");
    check("t4a_blinks", rises, 2);

    // Pulse on last OFF cycle with two queued
    rises = 0;
    step(1'b0, 1'b1, "t4b");
    step(1'b0, 1'b1, "t4b");
    step(1'b0, 1'b1, "t4b");
    idle(4, "t4b");
    step(1'b0, 1'b1, "t4b_last");
    check("t4b_pend_held", int'(pending), 2);
    idle(25, "t4b");
    check("t4b_blinks", rises, 4);

    // Six pulses: saturation, overflow sticky, exactly four blinks
    rises = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "t3");
    idle(35, "t3");
    check("t3_blinks", rises, 4);
    check("t3_ovf_sticky", int'(overflow), 1);

    // Reset mid-ON with queue and overflow set, pulse coincident
    rises = 0;
    step(1'b0, 1'b1, "t5");
    step(1'b0, 1'b1, "t5");
    step(1'b0, 1'b1, "t5");
    step(1'b1, 1'b1, "t5_rst");
    check("t5_led_off", int'(led_out), 0);
    rises = 0;
    idle(15, "t5");
    check("t5_no_blink", rises, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
